// File: rtl/sram_to_sram_pkg.sv
// sram_to_sram_pkg: shared widths, data types and drain FSM states for the SRAM-to-SRAM blocks
package sram_to_sram_pkg;
  localparam int ADDR_BITS = 10;
  localparam int DATA_BITS = 64;
  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [DATA_BITS-1:0] data_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
endpackage

// File: rtl/sram_to_sram_fifo2.sv
// sram_to_sram_fifo2: two-entry synchronous FIFO with occupancy output
module sram_to_sram_fifo2 #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   occ_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= ~wp_q;
      end
      if (pop_i) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end
  assign dout_o = mem_q[rp_q];
  assign occ_o  = cnt_q;
endmodule

// File: rtl/sram_to_sram_drain.sv
// sram_to_sram_drain: reads mem2/mem3 in address order and streams word pairs with back-pressure
module sram_to_sram_drain #(
  parameter int  ADDR_BITS = sram_to_sram_pkg::ADDR_BITS,
  parameter type addr_t    = logic [ADDR_BITS-1:0],
  parameter int  DATA_BITS = sram_to_sram_pkg::DATA_BITS,
  parameter type data_t    = logic [DATA_BITS-1:0]
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  cke,
  input  logic  start,
  input  addr_t len,
  output logic  busy,
  output logic  done,
  output logic  mem2_ren,
  output addr_t mem2_raddr,
  input  data_t mem2_rdata,
  output logic  mem3_ren,
  output addr_t mem3_raddr,
  input  data_t mem3_rdata,
  output data_t m_data0,
  output data_t m_data1,
  output logic  m_last,
  output logic  m_valid,
  input  logic  m_ready
);
  import sram_to_sram_pkg::*;
  state_e                 state_q, state_d;
  addr_t                  len_q, len_d, addr_q, addr_d;
  logic                   inflight_q, inflight_last_q, done_q, pop, at_end;
  logic [1:0]             occ;
  logic [2*DATA_BITS:0]   head;
  assign at_end  = addr_q == len_q;
  assign m_valid = occ != 2'd0;
  assign pop     = m_valid & m_ready & cke;
  // A read is issued only if its word is guaranteed a FIFO slot when it returns
  assign mem2_ren   = cke && state_q == RUN &&
                      ({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
  assign mem3_ren   = mem2_ren;
  assign mem2_raddr = addr_q;
  assign mem3_raddr = addr_q;
  assign m_data0    = head[DATA_BITS-1:0];
  assign m_data1    = head[2*DATA_BITS-1:DATA_BITS];
  assign m_last     = m_valid & head[2*DATA_BITS];
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      len_d   = len;
      addr_d  = '0;
    end
    if (state_q == RUN && mem2_ren) begin
      state_d = at_end ? FLUSH : RUN;
      addr_d  = at_end ? addr_q : addr_q + addr_t'(1);
    end
    if (state_q == FLUSH && pop && m_last) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      len_q           <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else if (cke) begin
      state_q         <= state_d;
      len_q           <= len_d;
      addr_q          <= addr_d;
      inflight_q      <= mem2_ren;
      inflight_last_q <= mem2_ren & at_end;
      done_q          <= pop & m_last;
    end
  end
  sram_to_sram_fifo2 #(.W(2*DATA_BITS+1)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (inflight_q & cke),
    .pop_i  (pop),
    .din_i  ({inflight_last_q, mem3_rdata, mem2_rdata}),
    .dout_o (head),
    .occ_o  (occ)
  );
endmodule

// File: tb/tb_sram_to_sram_drain.sv
// tb_sram_to_sram_drain: directed checks of the drain stream, back-pressure, restart and reset
module tb_sram_to_sram_drain;
  logic        clk = 1'b0;
  logic        reset, cke, start, m_ready;
  logic [9:0]  len;
  logic        busy, done, mem2_ren, mem3_ren, m_last, m_valid;
  logic [9:0]  mem2_raddr, mem3_raddr;
  logic [63:0] mem2_rdata, mem3_rdata, m_data0, m_data1;
  logic [63:0] m2 [1024];
  logic [63:0] m3 [1024];
  int          errors = 0;
  int          checks = 0;
  int          fv;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem2_ren) mem2_rdata <= m2[mem2_raddr];
    if (mem3_ren) mem3_rdata <= m3[mem3_raddr];
  end

  sram_to_sram_drain dut (
    .clk(clk), .reset(reset), .cke(cke), .start(start), .len(len),
    .busy(busy), .done(done),
    .mem2_ren(mem2_ren), .mem2_raddr(mem2_raddr), .mem2_rdata(mem2_rdata),
    .mem3_ren(mem3_ren), .mem3_raddr(mem3_raddr), .mem3_rdata(mem3_rdata),
    .m_data0(m_data0), .m_data1(m_data1), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [9:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: sink always ready; mode 1: pseudo-random ready pattern
  task automatic drain(input int n, input int mode, input int restart, output int first_v);
    int          idx, outst, issued;
    bit          stall, pr_ren, pr_pop, fin;
    logic [63:0] s0, s1;
    logic        sl;
    logic [15:0] pat;
    pat = 16'b1001_0110_1100_1011;
    idx = 0; outst = 0; issued = 0; stall = 0; fin = 0; first_v = -1;
    s0 = '0; s1 = '0; sl = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      m_ready = (mode == 0) ? 1'b1 : pat[cyc % 16];
      if (cyc == restart) begin
        start = 1'b1;
        len   = 10'd2;
      end else start = 1'b0;
      #1;
      if (m_valid && first_v < 0) first_v = cyc;
      if (stall) begin
        chk("stall_valid", {63'd0, m_valid}, 64'd1);
        chk("stall_data0", m_data0, s0);
        chk("stall_data1", m_data1, s1);
        chk("stall_last", {63'd0, m_last}, {63'd0, sl});
      end
      if (mem2_ren) begin
        chk("raddr_order", {54'd0, mem2_raddr}, 64'(issued));
        chk("raddr_banks", {54'd0, mem3_raddr}, 64'(issued));
        issued++;
      end
      if (m_valid && m_ready) begin
        chk("beat_data0", m_data0, 64'h100 + 64'(idx));
        chk("beat_data1", m_data1, 64'h200 + 64'(idx));
        chk("beat_last", {63'd0, m_last}, {63'd0, idx == n - 1});
        idx++;
        fin = idx == n;
      end
      stall  = m_valid && !m_ready;
      s0 = m_data0; s1 = m_data1; sl = m_last;
      pr_ren = mem2_ren;
      pr_pop = m_valid && m_ready;
      @(posedge clk); #1;
      outst = outst + int'(pr_ren) - int'(pr_pop);
      chk("outstanding_le2", {63'd0, outst <= 2}, 64'd1);
      if (!fin) chk("no_early_done", {63'd0, done}, 64'd0);
    end
    start = 1'b0;
    chk("beat_count", 64'(idx), 64'(n));
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("busy_fall", {63'd0, busy}, 64'd0);
    chk("valid_after", {63'd0, m_valid}, 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      m2[i] = 64'h100 + 64'(i);
      m3[i] = 64'h200 + 64'(i);
    end
    reset = 1'b1; cke = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ren", {63'd0, mem2_ren}, 64'd0);
    chk("rst_raddr", {54'd0, mem2_raddr}, 64'd0);
    chk("rst_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_last", {63'd0, m_last}, 64'd0);
    chk("rst_data0", m_data0, 64'd0);
    chk("rst_data1", m_data1, 64'd0);
    reset = 1'b0;

    go(10'd3);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_first_ren", {63'd0, mem2_ren}, 64'd1);
    chk("t1_first_raddr", {54'd0, mem2_raddr}, 64'd0);
    chk("t1_no_valid_yet", {63'd0, m_valid}, 64'd0);
    drain(4, 0, -1, fv);
    chk("t1_first_valid_cycle", 64'(fv), 64'd2);

    go(10'd0);
    drain(1, 0, -1, fv);

    go(10'd7);
    drain(8, 1, -1, fv);

    go(10'd1023);
    drain(1024, 0, -1, fv);

    go(10'd7);
    drain(8, 0, 3, fv);

    m_ready = 1'b0;
    go(10'd7);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_buffered_valid", {63'd0, m_valid}, 64'd1);
    chk("t6_buffered_head", m_data0, 64'h100);
    cke = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("cke_ren_forced0", {63'd0, mem2_ren}, 64'd0);
    @(posedge clk); #1;
    chk("cke_hold_valid", {63'd0, m_valid}, 64'd1);
    chk("cke_hold_head", m_data0, 64'h100);
    chk("cke_hold_busy", {63'd0, busy}, 64'd1);
    cke = 1'b1;
    m_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_rst_valid", {63'd0, m_valid}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_ren", {63'd0, mem2_ren}, 64'd0);
    chk("t6_rst_raddr", {54'd0, mem2_raddr}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t6_no_done", {63'd0, done}, 64'd0);
      chk("t6_no_beat", {63'd0, m_valid}, 64'd0);
    end
    go(10'd3);
    drain(4, 0, -1, fv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
